// File: rtl/traffic_light_pkg.sv
// Shared light-code and monitor-state constants for the traffic light FSM and monitor.
package traffic_light_pkg;

  // 2-bit light code driven by traffic_light_fsm
  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;
  localparam logic [1:0] LIGHT_BAD    = 2'b11;

  // Monitor states
  localparam logic [0:0] MON_SYNC  = 1'b0;
  localparam logic [0:0] MON_TRACK = 1'b1;

  // Only legal successor of a colour; the illegal code maps to RED (unused).
  function automatic logic [1:0] light_next(input logic [1:0] code);
    logic [1:0] nxt;
    case (code)
      LIGHT_RED:    nxt = LIGHT_GREEN;
      LIGHT_GREEN:  nxt = LIGHT_YELLOW;
      LIGHT_YELLOW: nxt = LIGHT_RED;
      default:      nxt = LIGHT_RED;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/light_lamp_decode.sv
// Registered light-code to one-hot lamp decoder; illegal code and reset drive red.
module light_lamp_decode
  import traffic_light_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] code_i,
  output logic       red_o,
  output logic       yellow_o,
  output logic       green_o
);

  logic red_q, yellow_q, green_q;

  // Decode every cycle regardless of monitor state; anything unknown shows red.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      red_q    <= 1'b1;
      yellow_q <= 1'b0;
      green_q  <= 1'b0;
    end else begin
      red_q    <= (code_i == LIGHT_RED) || (code_i == LIGHT_BAD);
      yellow_q <= (code_i == LIGHT_YELLOW);
      green_q  <= (code_i == LIGHT_GREEN);
    end
  end

  assign red_o    = red_q;
  assign yellow_o = yellow_q;
  assign green_o  = green_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: lamp decode, sequence/encoding/dwell checking and cycle count.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int unsigned RED_MIN    = 4,
  parameter int unsigned GREEN_MIN  = 4,
  parameter int unsigned YELLOW_MIN = 2,
  parameter int unsigned DWELL_W    = 8,
  parameter int unsigned CYC_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         light,
  input  logic               err_clr,
  output logic               red_lamp,
  output logic               yellow_lamp,
  output logic               green_lamp,
  output logic               locked,
  output logic               err_seq,
  output logic               err_dwell,
  output logic               err_code,
  output logic               err_any,
  output logic [DWELL_W-1:0] dwell,
  output logic [CYC_W-1:0]   cyc_cnt
);

  logic [0:0]         state_q, state_d;
  logic [1:0]         prev_q, prev_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               err_seq_q, err_seq_d;
  logic               err_dwell_q, err_dwell_d;
  logic               err_code_q, err_code_d;
  logic               err_any_q, err_any_d;
  logic               ev_seq, ev_dwell, ev_code;
  logic [31:0]        min_prev;

  // Minimum hold for the colour currently being tracked.
  function automatic logic [31:0] min_of(input logic [1:0] code);
    logic [31:0] m;
    case (code)
      LIGHT_RED:    m = RED_MIN;
      LIGHT_GREEN:  m = GREEN_MIN;
      LIGHT_YELLOW: m = YELLOW_MIN;
      default:      m = 32'd0;
    endcase
    return m;
  endfunction

  light_lamp_decode u_lamp (
    .clk_i    (clk),
    .rst_i    (reset),
    .code_i   (light),
    .red_o    (red_lamp),
    .yellow_o (yellow_lamp),
    .green_o  (green_lamp)
  );

  // Checker FSM: SYNC waits for RED to align, TRACK follows colour changes and dwell.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    dwell_d  = dwell_q;
    cyc_d    = cyc_q;
    ev_seq   = 1'b0;
    ev_dwell = 1'b0;
    ev_code  = 1'b0;
    min_prev = min_of(prev_q);
    case (state_q)
      MON_SYNC: begin
        dwell_d = '0;
        if (light == LIGHT_BAD) begin
          ev_code = 1'b1;
        end else if (light == LIGHT_RED) begin
          state_d = MON_TRACK;
          prev_d  = LIGHT_RED;
          dwell_d = {{(DWELL_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        if (light == LIGHT_BAD) begin
          ev_code = 1'b1;
          state_d = MON_SYNC;
          dwell_d = '0;
        end else if (light == prev_q) begin
          if (dwell_q != {DWELL_W{1'b1}}) dwell_d = dwell_q + 1'b1;
        end else begin
          ev_seq   = (light != light_next(prev_q));
          ev_dwell = (32'(dwell_q) < min_prev);
          prev_d   = light;
          dwell_d  = {{(DWELL_W-1){1'b0}}, 1'b1};
          if (prev_q == LIGHT_YELLOW && light == LIGHT_RED) cyc_d = cyc_q + 1'b1;
        end
      end
    endcase
  end

  // Sticky error flags: a fresh event outranks a coincident clear.
  always_comb begin
    err_seq_d   = ev_seq   | (err_seq_q   & ~err_clr);
    err_dwell_d = ev_dwell | (err_dwell_q & ~err_clr);
    err_code_d  = ev_code  | (err_code_q  & ~err_clr);
    err_any_d   = err_seq_d | err_dwell_d | err_code_d;
  end

  // State, counters and flags; reset returns to SYNC with everything cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MON_SYNC;
      prev_q      <= LIGHT_RED;
      dwell_q     <= '0;
      cyc_q       <= '0;
      err_seq_q   <= 1'b0;
      err_dwell_q <= 1'b0;
      err_code_q  <= 1'b0;
      err_any_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      dwell_q     <= dwell_d;
      cyc_q       <= cyc_d;
      err_seq_q   <= err_seq_d;
      err_dwell_q <= err_dwell_d;
      err_code_q  <= err_code_d;
      err_any_q   <= err_any_d;
    end
  end

  assign locked    = (state_q == MON_TRACK);
  assign err_seq   = err_seq_q;
  assign err_dwell = err_dwell_q;
  assign err_code  = err_code_q;
  assign err_any   = err_any_q;
  assign dwell     = dwell_q;
  assign cyc_cnt   = cyc_q;

endmodule
